instr_prefetch_queue: RTL and testbench

//  Instruction fetch front end: issues in-order word fetches to instruction memory and buffers
//  the returned words with their PC+4 in a small FIFO. Presents the head entry to the IF_ID

---
 rtl/instr_prefetch_queue.sv | 183 ++++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_prefetch_queue
//  Purpose  : Instruction fetch front end. Issues in-order word fetches,
//             buffers returned words with their PC+4 in a small FIFO and
//             presents the head entry (show-ahead) to the IF_ID register.
//             Handles ID stall and branch/jump redirect with stale-response
//             dropping.
//  Options  : PREFETCH_STATS_EN adds bubble / flush statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ID_stall,
   input  logic        ID_PCSrc,
   input  logic [31:0] ID_new_PC,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] IF_Instruction,
   output logic [31:0] IF_PC4,
`ifdef PREFETCH_STATS_EN
   output logic [31:0] stat_bubbles,
   output logic [31:0] stat_flushes,
`endif
   output logic        IF_Valid
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OUT_W = $clog2(MAX_OUT) + 1;

   // Queue storage (data only, no reset needed: read only when occupied)
   logic [31:0]      instr_buf_q [DEPTH];
   logic [31:0]      pc4_buf_q   [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   logic [OUT_W-1:0] drop_q, drop_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      enq_pc_q, enq_pc_d;

   logic             resp_ok;
   logic             head_valid;
   logic             req_ok;
   logic             issue;
   logic             pop;
   logic             push;
   logic [31:0]      in_flight;

   // Per-cycle event decode: issue / response / pop / push qualifiers
   always_comb begin
      resp_ok    = imem_resp_valid && (outstanding_q != '0);
      head_valid = (count_q != '0);
      in_flight  = 32'(count_q) + 32'(outstanding_q);
      // Occupancy plus in-flight never exceeds DEPTH, so every response has a slot
      req_ok     = Reset && !ID_PCSrc
                   && (32'(outstanding_q) < 32'(MAX_OUT))
                   && (in_flight < 32'(DEPTH));
      issue      = req_ok && imem_req_ready;
      pop        = head_valid && !ID_stall && !ID_PCSrc;
      push       = resp_ok && (drop_q == '0) && !ID_PCSrc;
   end

   // Next-state computation for pointers, counters and PCs
   always_comb begin
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      fetch_pc_d    = fetch_pc_q;
      enq_pc_d      = enq_pc_q;
      drop_d        = drop_q;
      outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(resp_ok);
      if (ID_PCSrc) begin
         // Flush: every request still in flight after this cycle is stale
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = ID_new_PC;
         enq_pc_d   = ID_new_PC;
         drop_d     = outstanding_d;
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            enq_pc_d = enq_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (resp_ok && (drop_q != '0)) begin
            drop_d = drop_q - OUT_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control state registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         fetch_pc_q    <= RESET_PC;
         enq_pc_q      <= RESET_PC;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         fetch_pc_q    <= fetch_pc_d;
         enq_pc_q      <= enq_pc_d;
      end
   end

   // Queue storage write: response word and its PC+4
   always_ff @(posedge Clk) begin
      if (push) begin
         instr_buf_q[wr_ptr_q] <= imem_resp_data;
         pc4_buf_q[wr_ptr_q]   <= enq_pc_q + 32'd4;
      end
   end

   // Show-ahead outputs; when empty, PC4 reflects the next expected instruction
   always_comb begin
      imem_req_valid = req_ok;
      imem_req_addr  = fetch_pc_q;
      IF_Valid       = head_valid;
      IF_Instruction = head_valid ? instr_buf_q[rd_ptr_q] : 32'h0;
      IF_PC4         = head_valid ? pc4_buf_q[rd_ptr_q] : (enq_pc_q + 32'd4);
   end

`ifdef PREFETCH_STATS_EN
   logic [31:0] bubbles_q, bubbles_d;
   logic [31:0] flushes_q, flushes_d;

   // Saturating statistics counters
   always_comb begin
      bubbles_d = bubbles_q;
      flushes_d = flushes_q;
      if (!head_valid && !ID_stall && !ID_PCSrc && (bubbles_q != '1)) begin
         bubbles_d = bubbles_q + 32'd1;
      end
      if (ID_PCSrc && (flushes_q != '1)) begin
         flushes_d = flushes_q + 32'd1;
      end
   end

   // Statistics registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         bubbles_q <= '0;
         flushes_q <= '0;
      end else begin
         bubbles_q <= bubbles_d;
         flushes_q <= flushes_d;
      end
   end

   assign stat_bubbles = bubbles_q;
   assign stat_flushes = flushes_q;
`endif

   // A response with nothing outstanding is a memory protocol error; it is ignored
   a_no_orphan_resp : assert property (@(posedge Clk) disable iff (!Reset)
      imem_resp_valid |-> (outstanding_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_instr_prefetch_queue
//  Purpose  : Directed self-checking bench for instr_prefetch_queue with a
//             queue-level reference model and a variable-latency memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_queue;
   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 4;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        ID_stall = 1'b0;
   logic        ID_PCSrc = 1'b0;
   logic [31:0] ID_new_PC = 32'h0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic [31:0] IF_Instruction;
   logic [31:0] IF_PC4;
   logic        IF_Valid;
`ifdef PREFETCH_STATS_EN
   logic [31:0] stat_bubbles;
   logic [31:0] stat_flushes;
`endif

   always #5 Clk = ~Clk;

   instr_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .ID_stall        (ID_stall),
      .ID_PCSrc        (ID_PCSrc),
      .ID_new_PC       (ID_new_PC),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .IF_Instruction  (IF_Instruction),
      .IF_PC4          (IF_PC4),
`ifdef PREFETCH_STATS_EN
      .stat_bubbles    (stat_bubbles),
      .stat_flushes    (stat_flushes),
`endif
      .IF_Valid        (IF_Valid)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Controls applied at the next cycle
   logic        nx_stall = 1'b0;
   logic        nx_pcsrc = 1'b0;
   logic        nx_ready = 1'b1;
   logic [31:0] nx_new_pc = 32'h0;
   int          lat = 1;
   int          cyc = 0;

   // Memory environment: accepted requests waiting for their response slot
   typedef struct { logic [31:0] addr; int due; } req_t;
   req_t mq[$];

   // Reference model: queue of {instruction, pc+4}
   typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
   ent_t        fifo[$];
   int          m_out;
   int          m_drop;
   logic [31:0] m_fetch;
   logic [31:0] m_enq;
   int          m_bub;
   int          m_flush;

   // Samples of the most recent cycle
   logic        s_valid;
   logic        s_req;
   logic [31:0] s_instr;
   logic [31:0] s_pc4;
   logic [31:0] s_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {8'h13, a[25:2]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      fifo.delete();
      mq.delete();
      m_out   = 0;
      m_drop  = 0;
      m_fetch = 32'h0;
      m_enq   = 32'h0;
      m_bub   = 0;
      m_flush = 0;
      cyc     = 0;
   endtask

   // One clock cycle: drive, compare against model, advance model
   task automatic tick();
      logic        rv;
      logic [31:0] rd;
      logic        e_valid;
      logic        e_req;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      req_t        r;
      ent_t        e;
      @(negedge Clk);
      ID_stall       = nx_stall;
      ID_PCSrc       = nx_pcsrc;
      ID_new_PC      = nx_new_pc;
      imem_req_ready = nx_ready;
      rv = 1'b0;
      rd = 32'h0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         rv = 1'b1;
         rd = mem_word(mq[0].addr);
         void'(mq.pop_front());
      end
      imem_resp_valid = rv;
      imem_resp_data  = rd;
      #1;
      e_valid = (fifo.size() > 0);
      e_instr = e_valid ? fifo[0].instr : 32'h0;
      e_pc4   = e_valid ? fifo[0].pc4 : m_enq + 32'd4;
      e_req   = !nx_pcsrc && (m_out < MAX_OUT) && (fifo.size() + m_out < DEPTH);
      chk("IF_Valid", {31'b0, IF_Valid}, {31'b0, e_valid});
      chk("IF_Instruction", IF_Instruction, e_instr);
      chk("IF_PC4", IF_PC4, e_pc4);
      chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
      chk("imem_req_addr", imem_req_addr, m_fetch);
`ifdef PREFETCH_STATS_EN
      chk("stat_bubbles", stat_bubbles, 32'(m_bub));
      chk("stat_flushes", stat_flushes, 32'(m_flush));
`endif
      s_valid = IF_Valid;
      s_req   = imem_req_valid;
      s_instr = IF_Instruction;
      s_pc4   = IF_PC4;
      s_addr  = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
         r.addr = imem_req_addr;
         r.due  = cyc + lat;
         mq.push_back(r);
      end
      if (!e_valid && !nx_stall && !nx_pcsrc) m_bub++;
      if (e_req && nx_ready) begin
         m_fetch = m_fetch + 32'd4;
         m_out++;
      end
      if (rv) m_out--;
      if (nx_pcsrc) begin
         fifo.delete();
         m_fetch = nx_new_pc;
         m_enq   = nx_new_pc;
         m_drop  = m_out;
         m_flush++;
      end else begin
         if (e_valid && !nx_stall) void'(fifo.pop_front());
         if (rv) begin
            if (m_drop > 0) m_drop--;
            else begin
               e.instr = rd;
               e.pc4   = m_enq + 32'd4;
               fifo.push_back(e);
               m_enq = m_enq + 32'd4;
            end
         end
      end
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   // Asynchronous reset pulse, asserted away from any clock edge
   task automatic do_reset();
      #2 Reset = 1'b0;
      #1;
      chk("rst_IF_Valid", {31'b0, IF_Valid}, 32'h0);
      chk("rst_IF_Instruction", IF_Instruction, 32'h0);
      chk("rst_IF_PC4", IF_PC4, 32'h4);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      imem_resp_valid = 1'b0;
      model_reset();
      @(posedge Clk);
      @(posedge Clk);
      #1 Reset = 1'b1;
   endtask

   initial begin
      int bubbles;

      // 1: streaming with 1-cycle memory
      nx_stall = 0; nx_pcsrc = 0; nx_ready = 1; lat = 1;
      do_reset();
      tick();
      chk("t1_first_req_valid", {31'b0, s_req}, 32'h1);
      chk("t1_first_req_addr", s_addr, 32'h0);
      tick();
      tick();
      chk("t1_head0_instr", s_instr, 32'h1300_0000);
      chk("t1_head0_pc4", s_pc4, 32'h4);
      tick();
      chk("t1_head1_instr", s_instr, 32'h1300_0001);
      chk("t1_head1_pc4", s_pc4, 32'h8);
      tick();
      chk("t1_head2_pc4", s_pc4, 32'hC);
      bubbles = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (!s_valid) bubbles++;
      end
      chk("t1_steady_bubbles", 32'(bubbles), 32'h0);

      // 2: long stall fills the queue, then drains back-to-back
      do_reset();
      nx_stall = 1;
      for (int i = 0; i < 8; i++) tick();
      chk("t2_full_req_valid", {31'b0, s_req}, 32'h0);
      chk("t2_full_head", s_instr, 32'h1300_0000);
      nx_stall = 0;
      tick(); chk("t2_pop0_pc4", s_pc4, 32'h4);
      tick(); chk("t2_pop1_pc4", s_pc4, 32'h8);
      tick(); chk("t2_pop2_pc4", s_pc4, 32'hC);
      tick(); chk("t2_pop3_pc4", s_pc4, 32'h10);
      for (int i = 0; i < 10; i++) tick();

      // 3: latency 3, two outstanding, redirect to 0x40
      do_reset();
      lat = 3; nx_ready = 1;
      tick();
      tick();
      nx_ready = 0; nx_pcsrc = 1; nx_new_pc = 32'h40;
      tick();
      chk("t3_redirect_req_valid", {31'b0, s_req}, 32'h0);
      nx_pcsrc = 0; nx_ready = 1;
      tick();
      chk("t3_after_req_valid", {31'b0, s_req}, 32'h1);
      chk("t3_after_req_addr", s_addr, 32'h40);
      chk("t3_empty_pc4", s_pc4, 32'h44);
      for (int i = 0; i < 20 && !s_valid; i++) tick();
      chk("t3_new_head_valid", {31'b0, s_valid}, 32'h1);
      chk("t3_new_head_instr", s_instr, 32'h1300_0010);
      chk("t3_new_head_pc4", s_pc4, 32'h44);
      for (int i = 0; i < 8; i++) tick();

      // 4: redirect with stall in the same cycle as a response
      do_reset();
      lat = 1; nx_stall = 1; nx_ready = 1;
      tick();
      nx_pcsrc = 1; nx_new_pc = 32'h100;
      tick();
      chk("t4_redirect_req_valid", {31'b0, s_req}, 32'h0);
      nx_pcsrc = 0;
      tick();
      chk("t4_flushed_valid", {31'b0, s_valid}, 32'h0);
      chk("t4_flushed_pc4", s_pc4, 32'h104);
      chk("t4_new_req_addr", s_addr, 32'h100);
      nx_stall = 0;
      for (int i = 0; i < 6; i++) tick();

      // 5: asynchronous reset with three entries queued
      do_reset();
      nx_stall = 1;
      for (int i = 0; i < 4; i++) tick();
      chk("t5_pre_reset_valid", {31'b0, s_valid}, 32'h1);
      do_reset();
      nx_stall = 0;
      tick();
      chk("t5_restart_addr", s_addr, 32'h0);
      chk("t5_restart_valid", {31'b0, s_valid}, 32'h0);
      for (int i = 0; i < 5; i++) tick();

`ifdef PREFETCH_STATS_EN
      // 6: statistics after a stalled memory and one redirect
      do_reset();
      nx_ready = 0;
      for (int i = 0; i < 5; i++) tick();
      nx_pcsrc = 1; nx_new_pc = 32'h200;
      tick();
      nx_pcsrc = 0; nx_ready = 1;
      tick();
      chk("t6_bubbles_ge5", {31'b0, (stat_bubbles >= 32'd5)}, 32'h1);
      chk("t6_flushes", stat_flushes, 32'h1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
